// File: rtl/ace_pkg.sv
// Shared types and constants for the I-cache refill controller.
//   refill_state_t : refill sequencer states
//   ACE_LINE_W     : I-cache line width in bits (eight 32-bit instructions)
//   ACE_LINE_OFF   : byte-offset bits within a line
//   ACE_BEAT_W     : default memory beat width
//   ACE_LINE_BEATS : default beats per line
package ace_pkg;

    localparam int unsigned ACE_LINE_W     = 256;
    localparam int unsigned ACE_LINE_OFF   = 5;
    localparam int unsigned ACE_BEAT_W     = 64;
    localparam int unsigned ACE_LINE_BEATS = 4;

    typedef enum logic [2:0] {
        StIdle,
        StReq,
        StResp,
        StFill,
        StDrain
    } refill_state_t;

endpackage

// File: rtl/ace_icache_refill_ctrl.sv
// I-cache line refill sequencer.
// Captures a fetch-miss address, issues one line read to memory, assembles
// LINE_BEATS data beats into a line and strobes it into the I-cache array.
// A retire flush abandons the refill; beats already granted are drained.
// Ports:
//   clock, reset_n       : clock, asynchronous active-low reset
//   icache_miss_i/pc     : miss request and fetch PC from the I-cache
//   retire_flush_i       : pipeline flush from retire
//   mem_req/addr/gnt     : line read request handshake
//   mem_rvalid/rdata     : returned data beats
//   refill_we/addr/line  : one-cycle line write into the I-cache array
//   icache_stall_o       : stall to fetch
//   refill_busy_o        : sequencer not idle
module ace_icache_refill_ctrl
    import ace_pkg::*;
#(
    parameter int unsigned ADDR_W     = 64,
    parameter int unsigned BEAT_W     = ACE_BEAT_W,
    parameter int unsigned LINE_BEATS = ACE_LINE_BEATS,
    localparam int unsigned LINE_W    = BEAT_W * LINE_BEATS
) (
    input  logic              clock,
    input  logic              reset_n,
    input  logic              icache_miss_i,
    input  logic [ADDR_W-1:0] miss_pc_i,
    input  logic              retire_flush_i,
    output logic              mem_req_o,
    output logic [ADDR_W-1:0] mem_addr_o,
    input  logic              mem_gnt_i,
    input  logic              mem_rvalid_i,
    input  logic [BEAT_W-1:0] mem_rdata_i,
    output logic              refill_we_o,
    output logic [ADDR_W-1:0] refill_addr_o,
    output logic [LINE_W-1:0] refill_line_o,
    output logic              icache_stall_o,
    output logic              refill_busy_o
);

    localparam int unsigned CntW = $clog2(LINE_BEATS);
    localparam logic [CntW-1:0] LastBeat = CntW'(LINE_BEATS - 1);

    refill_state_t state_q, state_d;
    logic [CntW-1:0] cnt_q, cnt_d;
    logic [ADDR_W-1:0] addr_q, addr_d;
    logic [LINE_BEATS-1:0][BEAT_W-1:0] line_q, line_d;

    // Offset bits of the PC never reach the line address.
    logic unused_pc_off;
    assign unused_pc_off = ^miss_pc_i[ACE_LINE_OFF-1:0];

    always_comb begin
        state_d     = state_q;
        cnt_d       = cnt_q;
        addr_d      = addr_q;
        line_d      = line_q;
        refill_we_o = 1'b0;

        unique case (state_q)
            StIdle: begin
                if (icache_miss_i && !retire_flush_i) begin
                    addr_d  = {miss_pc_i[ADDR_W-1:ACE_LINE_OFF], {ACE_LINE_OFF{1'b0}}};
                    cnt_d   = '0;
                    state_d = StReq;
                end
            end
            StReq: begin
                // A grant in the flush cycle commits the bus, so its beats must be drained.
                if (mem_gnt_i) begin
                    state_d = retire_flush_i ? StDrain : StResp;
                end else if (retire_flush_i) begin
                    state_d = StIdle;
                end
            end
            StResp: begin
                if (mem_rvalid_i) begin
                    line_d[cnt_q] = mem_rdata_i;
                    cnt_d         = cnt_q + 1'b1;
                end
                if (mem_rvalid_i && cnt_q == LastBeat) begin
                    // Last beat already arrived: nothing left to drain on a flush.
                    state_d = retire_flush_i ? StIdle : StFill;
                end else if (retire_flush_i) begin
                    state_d = StDrain;
                end
            end
            StFill: begin
                refill_we_o = !retire_flush_i;
                state_d     = StIdle;
            end
            StDrain: begin
                if (mem_rvalid_i) begin
                    cnt_d = cnt_q + 1'b1;
                    if (cnt_q == LastBeat) begin
                        state_d = StIdle;
                    end
                end
            end
            default: state_d = StIdle;
        endcase
    end

    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            state_q <= StIdle;
            cnt_q   <= '0;
            addr_q  <= '0;
            line_q  <= '0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            addr_q  <= addr_d;
            line_q  <= line_d;
        end
    end

    assign mem_req_o      = (state_q == StReq);
    assign mem_addr_o     = addr_q;
    assign refill_addr_o  = addr_q;
    assign refill_line_o  = line_q;
    assign refill_busy_o  = (state_q != StIdle);
    // DRAIN belongs to the abandoned stream and must not stall the redirected one.
    assign icache_stall_o = icache_miss_i ||
                            (state_q inside {StReq, StResp, StFill});

    // Beats are only legal while a granted read is outstanding.
    a_rvalid_legal: assert property (@(posedge clock) disable iff (!reset_n)
        mem_rvalid_i |-> (state_q inside {StResp, StDrain}));

endmodule

// File: tb/tb_ace_icache_refill_ctrl.sv
module tb_ace_icache_refill_ctrl;

    logic         clock = 1'b0;
    logic         reset_n;
    logic         icache_miss_i;
    logic [63:0]  miss_pc_i;
    logic         retire_flush_i;
    logic         mem_req_o;
    logic [63:0]  mem_addr_o;
    logic         mem_gnt_i;
    logic         mem_rvalid_i;
    logic [63:0]  mem_rdata_i;
    logic         refill_we_o;
    logic [63:0]  refill_addr_o;
    logic [255:0] refill_line_o;
    logic         icache_stall_o;
    logic         refill_busy_o;

    typedef struct packed {
        logic [63:0]  addr;
        logic [255:0] line;
    } exp_t;

    exp_t sb_q[$];
    int   checks = 0;
    int   errors = 0;
    int   n_writes = 0;

    ace_icache_refill_ctrl dut (
        .clock          (clock),
        .reset_n        (reset_n),
        .icache_miss_i  (icache_miss_i),
        .miss_pc_i      (miss_pc_i),
        .retire_flush_i (retire_flush_i),
        .mem_req_o      (mem_req_o),
        .mem_addr_o     (mem_addr_o),
        .mem_gnt_i      (mem_gnt_i),
        .mem_rvalid_i   (mem_rvalid_i),
        .mem_rdata_i    (mem_rdata_i),
        .refill_we_o    (refill_we_o),
        .refill_addr_o  (refill_addr_o),
        .refill_line_o  (refill_line_o),
        .icache_stall_o (icache_stall_o),
        .refill_busy_o  (refill_busy_o)
    );

    always #5 clock = ~clock;

    initial begin
        #200000;
        $display("FAIL timeout: simulation did not complete");
        $fatal(1, "timeout");
    end

    task automatic chk(input string tag, input logic [255:0] obs, input logic [255:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    // Advance one cycle; any write strobe is matched against the scoreboard.
    task automatic step();
        exp_t e;
        @(posedge clock);
        #1;
        if (refill_we_o === 1'b1) begin
            n_writes++;
            chk("we_expected", 256'(sb_q.size() != 0), 256'(1));
            if (sb_q.size() != 0) begin
                e = sb_q.pop_front();
                chk("refill_addr", refill_addr_o, e.addr);
                chk("refill_line", refill_line_o, e.line);
            end
        end
    endtask

    task automatic beat(input logic [63:0] d);
        mem_rvalid_i = 1'b1;
        mem_rdata_i  = d;
        step();
        mem_rvalid_i = 1'b0;
        mem_rdata_i  = '0;
    endtask

    function automatic logic [63:0] rnd64();
        return {$urandom, $urandom};
    endfunction

    initial begin
        exp_t        e;
        logic [63:0] b [4];
        int          w0;

        reset_n        = 1'b0;
        icache_miss_i  = 1'b0;
        miss_pc_i      = '0;
        retire_flush_i = 1'b0;
        mem_gnt_i      = 1'b0;
        mem_rvalid_i   = 1'b0;
        mem_rdata_i    = '0;

        // Reset state
        #12;
        chk("rst_req", mem_req_o, 0);
        chk("rst_we", refill_we_o, 0);
        chk("rst_addr", mem_addr_o, 0);
        chk("rst_raddr", refill_addr_o, 0);
        chk("rst_line", refill_line_o, 0);
        chk("rst_stall", icache_stall_o, 0);
        chk("rst_busy", refill_busy_o, 0);
        reset_n = 1'b1;
        step();

        // Basic refill: grant at t+1, four back-to-back beats, write at t+6
        b[0] = {16{4'h1}}; b[1] = {16{4'h2}}; b[2] = {16{4'h3}}; b[3] = {16{4'h4}};
        e.addr = 64'h1000_0020;
        e.line = {b[3], b[2], b[1], b[0]};
        sb_q.push_back(e);
        icache_miss_i = 1'b1;
        miss_pc_i     = 64'h1000_0024;
        step();                                   // t+1
        icache_miss_i = 1'b0;
        chk("basic_req", mem_req_o, 1);
        chk("basic_addr", mem_addr_o, 64'h1000_0020);
        chk("basic_stall", icache_stall_o, 1);
        mem_gnt_i = 1'b1;
        step();                                   // t+2
        mem_gnt_i = 1'b0;
        chk("basic_req_drop", mem_req_o, 0);
        beat(b[0]);
        beat(b[1]);
        beat(b[2]);
        chk("basic_we_early", refill_we_o, 0);    // t+5
        w0 = n_writes;
        beat(b[3]);                               // t+6
        chk("basic_we_t6", refill_we_o, 1);
        chk("basic_stall_fill", icache_stall_o, 1);
        step();                                   // t+7
        chk("basic_stall_t7", icache_stall_o, 0);
        chk("basic_busy_t7", refill_busy_o, 0);
        chk("basic_writes", n_writes - w0, 1);

        // Delayed grant and gapped beats
        for (int i = 0; i < 4; i++) b[i] = rnd64();
        e.addr = 64'h2000_0040;
        e.line = {b[3], b[2], b[1], b[0]};
        sb_q.push_back(e);
        w0 = n_writes;
        icache_miss_i = 1'b1;
        miss_pc_i     = 64'h2000_0048;
        step();
        icache_miss_i = 1'b0;
        for (int i = 0; i < 3; i++) begin
            chk("dly_req", mem_req_o, 1);
            chk("dly_addr", mem_addr_o, 64'h2000_0040);
            step();
        end
        chk("dly_req_last", mem_req_o, 1);
        mem_gnt_i = 1'b1;
        step();
        mem_gnt_i = 1'b0;
        for (int i = 0; i < 4; i++) begin
            beat(b[i]);
            step();
        end
        step();
        chk("dly_writes", n_writes - w0, 1);

        // Flush in REQ before any grant
        w0 = n_writes;
        icache_miss_i = 1'b1;
        miss_pc_i     = 64'h3000_0100;
        step();
        icache_miss_i = 1'b0;
        step();
        chk("freq_req_held", mem_req_o, 1);
        retire_flush_i = 1'b1;
        step();
        retire_flush_i = 1'b0;
        chk("freq_req_drop", mem_req_o, 0);
        chk("freq_busy", refill_busy_o, 0);
        step();
        step();
        chk("freq_writes", n_writes - w0, 0);

        // Flush in RESP after two beats; remaining beats drained
        w0 = n_writes;
        icache_miss_i = 1'b1;
        miss_pc_i     = 64'h4000_0000;
        step();
        icache_miss_i = 1'b0;
        mem_gnt_i = 1'b1;
        step();
        mem_gnt_i = 1'b0;
        beat(rnd64());
        beat(rnd64());
        retire_flush_i = 1'b1;
        step();
        retire_flush_i = 1'b0;
        chk("fresp_stall", icache_stall_o, 0);
        chk("fresp_busy", refill_busy_o, 1);
        beat(rnd64());
        chk("fresp_stall_drain", icache_stall_o, 0);
        chk("fresp_busy_drain", refill_busy_o, 1);
        beat(rnd64());
        chk("fresp_idle", refill_busy_o, 0);
        step();
        chk("fresp_writes", n_writes - w0, 0);

        // Miss presented during DRAIN is accepted only once IDLE
        icache_miss_i = 1'b1;
        miss_pc_i     = 64'h5000_0080;
        step();
        icache_miss_i = 1'b0;
        mem_gnt_i = 1'b1;
        step();
        mem_gnt_i = 1'b0;
        beat(rnd64());
        beat(rnd64());
        retire_flush_i = 1'b1;
        step();
        retire_flush_i = 1'b0;
        for (int i = 0; i < 4; i++) b[i] = rnd64();
        e.addr = 64'h6000_0000;
        e.line = {b[3], b[2], b[1], b[0]};
        sb_q.push_back(e);
        icache_miss_i = 1'b1;
        miss_pc_i     = 64'h6000_0010;
        #1;
        chk("mdrain_stall", icache_stall_o, 1);
        beat(rnd64());
        chk("mdrain_req", mem_req_o, 0);
        chk("mdrain_stall2", icache_stall_o, 1);
        beat(rnd64());
        chk("mdrain_idle", refill_busy_o, 0);
        chk("mdrain_idle_req", mem_req_o, 0);
        chk("mdrain_idle_stall", icache_stall_o, 1);
        step();
        icache_miss_i = 1'b0;
        chk("mdrain_new_req", mem_req_o, 1);
        chk("mdrain_new_addr", mem_addr_o, 64'h6000_0000);
        w0 = n_writes;
        mem_gnt_i = 1'b1;
        step();
        mem_gnt_i = 1'b0;
        for (int i = 0; i < 4; i++) beat(b[i]);
        step();
        chk("mdrain_writes", n_writes - w0, 1);

        // Asynchronous reset mid-RESP, then a clean refill
        icache_miss_i = 1'b1;
        miss_pc_i     = 64'h7000_0000;
        step();
        icache_miss_i = 1'b0;
        mem_gnt_i = 1'b1;
        step();
        mem_gnt_i = 1'b0;
        beat(64'hdead_beef_0000_0001);
        beat(64'hdead_beef_0000_0002);
        reset_n = 1'b0;
        #1;
        chk("mrst_req", mem_req_o, 0);
        chk("mrst_busy", refill_busy_o, 0);
        chk("mrst_line", refill_line_o, 0);
        chk("mrst_addr", refill_addr_o, 0);
        chk("mrst_maddr", mem_addr_o, 0);
        chk("mrst_stall", icache_stall_o, 0);
        #2;
        reset_n = 1'b1;
        step();
        for (int i = 0; i < 4; i++) b[i] = rnd64();
        e.addr = 64'h7000_1000;
        e.line = {b[3], b[2], b[1], b[0]};
        sb_q.push_back(e);
        w0 = n_writes;
        icache_miss_i = 1'b1;
        miss_pc_i     = 64'h7000_101c;
        step();
        icache_miss_i = 1'b0;
        chk("mrst_new_addr", mem_addr_o, 64'h7000_1000);
        mem_gnt_i = 1'b1;
        step();
        mem_gnt_i = 1'b0;
        for (int i = 0; i < 4; i++) beat(b[i]);
        step();
        chk("mrst_writes", n_writes - w0, 1);

        chk("sb_empty", 256'(sb_q.size()), 0);
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule

// File: doc/ace_icache_refill_ctrl.md
# ace_icache_refill_ctrl

Sequences an I-cache line refill on a fetch miss. It captures the miss address, requests the line from the memory bus, and assembles four 64-bit beats into one 256-bit line (eight instructions, the `icache_instalign` width). It then writes the line into the I-cache array. It sits between the I-cache and the memory interface, drives the fetch-side `icache_stall` and honours `retire_flush`.

## Interface
Parameters:
- ADDR_W, 64, address width.
- BEAT_W, 64, memory data beat width.
- LINE_BEATS, 4, beats per line; LINE_W = BEAT_W*LINE_BEATS = 256.

Ports:
- clock  in  1  single clock, rising edge.
- reset_n  in  1  asynchronous, active-low reset.
- icache_miss_i  in  1  lookup of `miss_pc_i` missed this cycle.
- miss_pc_i  in  ADDR_W  fetch PC of the miss (`pcgen_pc_f1`).
- retire_flush_i  in  1  pipeline flush from retire.
- mem_req_o  out  1  line read request.
- mem_addr_o  out  ADDR_W  line address, bits [4:0] = 0.
- mem_gnt_i  in  1  request accepted when mem_req_o & mem_gnt_i.
- mem_rvalid_i  in  1  data beat valid.
- mem_rdata_i  in  BEAT_W  data beat.
- refill_we_o  out  1  one-cycle I-cache write strobe.
- refill_addr_o  out  ADDR_W  line address being written.
- refill_line_o  out  LINE_W  assembled line; beat k in bits [64k+63:64k].
- icache_stall_o  out  1  stall to fetch.
- refill_busy_o  out  1  state != IDLE.

## Operation
- States: IDLE, REQ, RESP, FILL, DRAIN.
- IDLE:
  - When icache_miss_i & !retire_flush_i, latch {miss_pc_i[63:5], 5'b0} into the address register, clear the beat counter and go to REQ.
  - When retire_flush_i is high, do not start a refill.
- REQ:
  - mem_req_o = 1 with mem_addr_o stable.
  - On mem_gnt_i, go to RESP.
  - On retire_flush_i before grant, withdraw the request and go to IDLE.
  - If flush and grant occur in the same cycle, the grant counts and the next state is DRAIN.
- RESP:
  - Each mem_rvalid_i writes mem_rdata_i into beat slot cnt, then cnt increments (2-bit, 0..3).
  - The beat with cnt==3 goes to FILL.
  - retire_flush_i goes to DRAIN. A beat arriving in the flush cycle is still counted.
- FILL: refill_we_o = 1 for exactly one cycle, then go to IDLE. If retire_flush_i is high in FILL, refill_we_o is forced to 0 and the next state is IDLE.
- DRAIN:
  - Consume the remaining beats up to cnt==3 without storing them, then go to IDLE.
  - refill_we_o is never asserted for a flushed line.
- A miss arriving in any non-IDLE state is not latched. Fetch keeps presenting it (held by stall) until IDLE accepts it.
- mem_rvalid_i outside RESP/DRAIN is a protocol error. It is ignored and flagged by an assertion.
- icache_stall_o = icache_miss_i | (state ∈ {REQ, RESP, FILL}). DRAIN does not stall hits from the redirected stream.

## Timing
- Reset values: state IDLE, cnt 0, and all outputs 0, including refill_line_o and refill_addr_o.
- Miss at cycle t: mem_req_o high at t+1, since it comes from a registered state.
- Grant at cycle g: beats accepted from g+1 onward, one per mem_rvalid_i cycle, with back-to-back beats allowed.
- Last beat at cycle b: refill_we_o high in b+1, state IDLE in b+2. A new miss can then request at b+3.
- Minimum miss-to-write latency, with grant at t+1 and four back-to-back beats: refill_we_o at t+6.
- icache_stall_o is combinational from icache_miss_i and registered state. It drops in the cycle after FILL unless a new miss is presented.
- Asynchronous reset mid-transaction abandons the bus transaction. The memory side is reset by the same reset_n.

## Structure
- ace_pkg holds:
  - the refill_state_t enum (IDLE, REQ, RESP, FILL, DRAIN);
  - the ACE_LINE_W = 256 and ACE_LINE_OFF = 5 constants;
  - the BEAT_W and LINE_BEATS defaults.
- Single module, with no sub-module. The line assembly buffer and beat counter are inline.

## Test plan
- Basic refill: miss at PC 0x1000_0024. Expect:
  - mem_addr_o = 0x1000_0020;
  - mem_gnt_i immediately, then beats 0x11..11, 0x22..22, 0x33..33 and 0x44..44 back-to-back;
  - refill_we_o at t+6 with the line = {0x44..44, 0x33..33, 0x22..22, 0x11..11};
  - icache_stall_o low at t+7.
- Delayed grant and gapped beats: mem_gnt_i after 3 cycles and rvalid on every other cycle. Expect mem_addr_o stable throughout REQ and exactly one refill_we_o after the 4th beat.
- Flush in REQ: flush 1 cycle after mem_req_o rises, with no grant. Expect mem_req_o low next cycle, state IDLE and no refill_we_o.
- Flush in RESP: flush after beat 1. Expect DRAIN to consume beats 2–3, refill_we_o to stay 0, and icache_stall_o low from the flush+1 cycle.
- Miss during DRAIN: icache_miss_i held high during DRAIN. Expect icache_stall_o high, and a new request one cycle after the state returns to IDLE, with the new address.
- Reset mid-RESP: assert reset_n low after beat 2. Expect all outputs 0 immediately, and the next miss to start a clean refill with cnt = 0.
